// File: rtl/add_reservation_station_if.sv
// Issue/dispatch bundle of the adder reservation station.
// The result-bus signals exist only when ADD_RS_CDB_EN is defined.
interface add_reservation_station_if;
    logic [7:0] Operand1;
    logic [7:0] Operand2;
    logic [2:0] Operand1_Tag;
    logic [2:0] Operand2_Tag;
    logic       Operand1_Vbit;
    logic       Operand2_Vbit;
    logic       ADD_Status;
`ifdef ADD_RS_CDB_EN
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [7:0] cdb_data;
`endif
    logic [2:0] ADD_Tag_ip;
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       AR_Status;
    logic [7:0] AR_Out_Operand1;
    logic [7:0] AR_Out_Operand2;
    logic [2:0] select;

`ifdef ADD_RS_CDB_EN
    modport master (
        output Operand1, Operand2, Operand1_Tag, Operand2_Tag,
               Operand1_Vbit, Operand2_Vbit, ADD_Status,
               cdb_valid, cdb_tag, cdb_data,
        input  ADD_Tag_ip, E1, E2, E3, E4, AR_Status,
               AR_Out_Operand1, AR_Out_Operand2, select
    );
    modport slave (
        input  Operand1, Operand2, Operand1_Tag, Operand2_Tag,
               Operand1_Vbit, Operand2_Vbit, ADD_Status,
               cdb_valid, cdb_tag, cdb_data,
        output ADD_Tag_ip, E1, E2, E3, E4, AR_Status,
               AR_Out_Operand1, AR_Out_Operand2, select
    );
`else
    modport master (
        output Operand1, Operand2, Operand1_Tag, Operand2_Tag,
               Operand1_Vbit, Operand2_Vbit, ADD_Status,
        input  ADD_Tag_ip, E1, E2, E3, E4, AR_Status,
               AR_Out_Operand1, AR_Out_Operand2, select
    );
    modport slave (
        input  Operand1, Operand2, Operand1_Tag, Operand2_Tag,
               Operand1_Vbit, Operand2_Vbit, ADD_Status,
        output ADD_Tag_ip, E1, E2, E3, E4, AR_Status,
               AR_Out_Operand1, AR_Out_Operand2, select
    );
`endif
endinterface

// File: rtl/add_reservation_station.sv
// Four-entry reservation station feeding the 8-bit adder.
// Optional result-bus wakeup of waiting operands: define ADD_RS_CDB_EN.
module add_reservation_station (
    input  logic                      clk,
    input  logic                      rst_n,
    add_reservation_station_if.slave  rs
);
    logic [3:0] busy_r;
    logic [3:0] busy_n_s;
    logic [3:0] v1_r;
    logic [3:0] v1_n_s;
    logic [3:0] v2_r;
    logic [3:0] v2_n_s;
    logic [7:0] val1_r   [4];
    logic [7:0] val1_n_s [4];
    logic [7:0] val2_r   [4];
    logic [7:0] val2_n_s [4];

    logic [3:0] ready_s;
    logic [2:0] alloc_tag_s;
    logic [1:0] alloc_idx_s;
    logic       alloc_en_s;
    logic [2:0] disp_tag_s;
    logic [1:0] disp_idx_s;
    logic       disp_en_s;

    logic       in_v1_s;
    logic       in_v2_s;
    logic [7:0] in_val1_s;
    logic [7:0] in_val2_s;
    logic [3:0] wake1_s;
    logic [3:0] wake2_s;
    logic [7:0] cdb_data_s;

    logic       ar_status_r;
    logic [2:0] select_r;
    logic [7:0] ar_op1_r;
    logic [7:0] ar_op2_r;

    // Tag (1..4) of the lowest set bit, 0 when none is set.
    function automatic logic [2:0] first_tag(input logic [3:0] vec);
        logic [2:0] tag_v;
        casez (vec)
            4'b???1: tag_v = 3'd1;
            4'b??10: tag_v = 3'd2;
            4'b?100: tag_v = 3'd3;
            4'b1000: tag_v = 3'd4;
            default: tag_v = 3'd0;
        endcase
        return tag_v;
    endfunction

    function automatic logic [1:0] tag_to_idx(input logic [2:0] tag);
        logic [1:0] idx_v;
        case (tag)
            3'd2:    idx_v = 2'd1;
            3'd3:    idx_v = 2'd2;
            3'd4:    idx_v = 2'd3;
            default: idx_v = 2'd0;
        endcase
        return idx_v;
    endfunction

    assign alloc_tag_s = first_tag(~busy_r);
    assign alloc_idx_s = tag_to_idx(alloc_tag_s);
    assign alloc_en_s  = (alloc_tag_s != 3'd0);

    assign ready_s     = busy_r & v1_r & v2_r;
    assign disp_tag_s  = first_tag(ready_s);
    assign disp_idx_s  = tag_to_idx(disp_tag_s);
    assign disp_en_s   = ~rs.ADD_Status & (disp_tag_s != 3'd0);

`ifdef ADD_RS_CDB_EN
    logic [2:0] tag1_r   [4];
    logic [2:0] tag1_n_s [4];
    logic [2:0] tag2_r   [4];
    logic [2:0] tag2_n_s [4];
    logic       in_hit1_s;
    logic       in_hit2_s;

    assign cdb_data_s = rs.cdb_data;

    // Broadcast matching: stored waiting operands and the operands being issued this edge.
    always_comb begin
        wake1_s   = 4'b0000;
        wake2_s   = 4'b0000;
        in_hit1_s = rs.cdb_valid & ~rs.Operand1_Vbit & (rs.Operand1_Tag == rs.cdb_tag);
        in_hit2_s = rs.cdb_valid & ~rs.Operand2_Vbit & (rs.Operand2_Tag == rs.cdb_tag);
        for (int i = 0; i < 4; i++) begin
            wake1_s[i] = rs.cdb_valid & busy_r[i] & ~v1_r[i] & (tag1_r[i] == rs.cdb_tag);
            wake2_s[i] = rs.cdb_valid & busy_r[i] & ~v2_r[i] & (tag2_r[i] == rs.cdb_tag);
        end
        in_v1_s = rs.Operand1_Vbit | in_hit1_s;
        in_v2_s = rs.Operand2_Vbit | in_hit2_s;
        if (in_hit1_s) begin
            in_val1_s = rs.cdb_data;
        end else begin
            in_val1_s = rs.Operand1;
        end
        if (in_hit2_s) begin
            in_val2_s = rs.cdb_data;
        end else begin
            in_val2_s = rs.Operand2;
        end
    end

    // Producer tags are only kept while the wakeup path exists.
    always_comb begin
        tag1_n_s = tag1_r;
        tag2_n_s = tag2_r;
        for (int i = 0; i < 4; i++) begin
            if (alloc_en_s && (alloc_idx_s == 2'(i))) begin
                tag1_n_s[i] = rs.Operand1_Tag;
                tag2_n_s[i] = rs.Operand2_Tag;
            end else begin
                tag1_n_s[i] = tag1_r[i];
                tag2_n_s[i] = tag2_r[i];
            end
        end
    end

    // Producer tag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                tag1_r[i] <= 3'd0;
                tag2_r[i] <= 3'd0;
            end
        end else begin
            tag1_r <= tag1_n_s;
            tag2_r <= tag2_n_s;
        end
    end
`else
    logic unused_tags_s;

    // Without the result bus a waiting operand can never be satisfied.
    assign unused_tags_s = ^{rs.Operand1_Tag, rs.Operand2_Tag};
    assign cdb_data_s    = 8'd0;
    assign wake1_s       = 4'b0000;
    assign wake2_s       = 4'b0000;
    assign in_v1_s       = rs.Operand1_Vbit;
    assign in_v2_s       = rs.Operand2_Vbit;
    assign in_val1_s     = rs.Operand1;
    assign in_val2_s     = rs.Operand2;
`endif

    // Per-entry next state: an allocated entry was free and a dispatched entry was ready,
    // so neither can also be waiting on the broadcast.
    always_comb begin
        busy_n_s = busy_r;
        v1_n_s   = v1_r;
        v2_n_s   = v2_r;
        val1_n_s = val1_r;
        val2_n_s = val2_r;
        for (int i = 0; i < 4; i++) begin
            if (alloc_en_s && (alloc_idx_s == 2'(i))) begin
                busy_n_s[i] = 1'b1;
                v1_n_s[i]   = in_v1_s;
                v2_n_s[i]   = in_v2_s;
                val1_n_s[i] = in_val1_s;
                val2_n_s[i] = in_val2_s;
            end else if (disp_en_s && (disp_idx_s == 2'(i))) begin
                busy_n_s[i] = 1'b0;
            end else begin
                if (wake1_s[i]) begin
                    v1_n_s[i]   = 1'b1;
                    val1_n_s[i] = cdb_data_s;
                end else begin
                    v1_n_s[i]   = v1_r[i];
                end
                if (wake2_s[i]) begin
                    v2_n_s[i]   = 1'b1;
                    val2_n_s[i] = cdb_data_s;
                end else begin
                    v2_n_s[i]   = v2_r[i];
                end
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 4'b0000;
            v1_r   <= 4'b0000;
            v2_r   <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                val1_r[i] <= 8'd0;
                val2_r[i] <= 8'd0;
            end
        end else begin
            busy_r <= busy_n_s;
            v1_r   <= v1_n_s;
            v2_r   <= v2_n_s;
            val1_r <= val1_n_s;
            val2_r <= val2_n_s;
        end
    end

    // Dispatch register toward the adder; operands hold between dispatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_status_r <= 1'b0;
            select_r    <= 3'd0;
            ar_op1_r    <= 8'd0;
            ar_op2_r    <= 8'd0;
        end else if (disp_en_s) begin
            ar_status_r <= 1'b1;
            select_r    <= disp_tag_s;
            ar_op1_r    <= val1_r[disp_idx_s];
            ar_op2_r    <= val2_r[disp_idx_s];
        end else begin
            ar_status_r <= 1'b0;
            select_r    <= 3'd0;
        end
    end

    assign rs.ADD_Tag_ip      = alloc_tag_s;
    assign rs.E1              = busy_r[0];
    assign rs.E2              = busy_r[1];
    assign rs.E3              = busy_r[2];
    assign rs.E4              = busy_r[3];
    assign rs.AR_Status       = ar_status_r;
    assign rs.select          = select_r;
    assign rs.AR_Out_Operand1 = ar_op1_r;
    assign rs.AR_Out_Operand2 = ar_op2_r;
endmodule

// File: tb/tb_add_reservation_station.sv
// Directed and random checks of add_reservation_station against a behavioural model.
module tb_add_reservation_station;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    add_reservation_station_if bus();

    add_reservation_station dut (.clk(clk), .rst_n(rst_n), .rs(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Inputs as presented for the coming edge.
    logic [7:0] i_op1, i_op2, i_cd;
    logic [2:0] i_t1, i_t2, i_ct;
    logic       i_b1, i_b2, i_st, i_cv;

    // Model: the set of held instructions plus the last dispatch.
    logic       m_busy [4];
    logic       m_v1 [4];
    logic       m_v2 [4];
    logic [7:0] m_val1 [4];
    logic [7:0] m_val2 [4];
    logic [2:0] m_tag1 [4];
    logic [2:0] m_tag2 [4];
    logic       e_ars;
    logic [2:0] e_sel;
    logic [7:0] e_o1, e_o2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 1'b0; m_v1[i] = 1'b0; m_v2[i] = 1'b0;
            m_val1[i] = 8'd0; m_val2[i] = 8'd0; m_tag1[i] = 3'd0; m_tag2[i] = 3'd0;
        end
        e_ars = 1'b0; e_sel = 3'd0; e_o1 = 8'd0; e_o2 = 8'd0;
    endtask

    task automatic model_edge();
        int f;
        int r;
        logic hit1, hit2;
        f = -1;
        r = -1;
        for (int i = 0; i < 4; i++) if (!m_busy[i] && f < 0) f = i;
        if (!i_st) for (int i = 0; i < 4; i++) if (m_busy[i] && m_v1[i] && m_v2[i] && r < 0) r = i;
        if (r >= 0) begin
            e_ars = 1'b1; e_sel = 3'(r + 1); e_o1 = m_val1[r]; e_o2 = m_val2[r];
        end else begin
            e_ars = 1'b0; e_sel = 3'd0;
        end
        if (i_cv) for (int i = 0; i < 4; i++) if (m_busy[i]) begin
            if (!m_v1[i] && m_tag1[i] == i_ct) begin m_v1[i] = 1'b1; m_val1[i] = i_cd; end
            if (!m_v2[i] && m_tag2[i] == i_ct) begin m_v2[i] = 1'b1; m_val2[i] = i_cd; end
        end
        if (f >= 0) begin
            hit1 = i_cv && !i_b1 && (i_t1 == i_ct);
            hit2 = i_cv && !i_b2 && (i_t2 == i_ct);
            m_busy[f] = 1'b1;
            m_v1[f] = i_b1 || hit1;  m_val1[f] = hit1 ? i_cd : i_op1;  m_tag1[f] = i_t1;
            m_v2[f] = i_b2 || hit2;  m_val2[f] = hit2 ? i_cd : i_op2;  m_tag2[f] = i_t2;
        end
        if (r >= 0) m_busy[r] = 1'b0;
    endtask

    task automatic check_all();
        logic [2:0] exp_tag;
        exp_tag = 3'd0;
        for (int i = 3; i >= 0; i--) if (!m_busy[i]) exp_tag = 3'(i + 1);
        chk("busy_flags", {4'd0, bus.E4, bus.E3, bus.E2, bus.E1},
            {4'd0, m_busy[3], m_busy[2], m_busy[1], m_busy[0]});
        chk("ADD_Tag_ip", {5'd0, bus.ADD_Tag_ip}, {5'd0, exp_tag});
        chk("AR_Status", {7'd0, bus.AR_Status}, {7'd0, e_ars});
        chk("select", {5'd0, bus.select}, {5'd0, e_sel});
        chk("AR_Out_Operand1", bus.AR_Out_Operand1, e_o1);
        chk("AR_Out_Operand2", bus.AR_Out_Operand2, e_o2);
    endtask

    task automatic drive(input logic [7:0] o1, input logic [7:0] o2, input logic [2:0] t1,
                         input logic [2:0] t2, input logic b1, input logic b2, input logic st);
        i_op1 = o1; i_op2 = o2; i_t1 = t1; i_t2 = t2; i_b1 = b1; i_b2 = b2; i_st = st;
        bus.Operand1 = o1; bus.Operand2 = o2; bus.Operand1_Tag = t1; bus.Operand2_Tag = t2;
        bus.Operand1_Vbit = b1; bus.Operand2_Vbit = b2; bus.ADD_Status = st;
    endtask

    task automatic set_cdb(input logic cv, input logic [2:0] ct, input logic [7:0] cd);
`ifdef ADD_RS_CDB_EN
        i_cv = cv; i_ct = ct; i_cd = cd;
        bus.cdb_valid = cv; bus.cdb_tag = ct; bus.cdb_data = cd;
`else
        i_cv = 1'b0; i_ct = ct; i_cd = cd;
        if (cv) $display("note: result bus not built, broadcast ignored");
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_cdb(1'b0, 3'd0, 8'h00);
        do_reset();

        // Single ready instruction, then identical instructions keep arriving.
        drive(8'h08, 8'h04, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t1_E1_after_e1", {7'd0, bus.E1}, 8'd1);
        chk("t1_tag_after_e1", {5'd0, bus.ADD_Tag_ip}, 8'd2);
        tick();
        chk("t1_ars_after_e2", {7'd0, bus.AR_Status}, 8'd1);
        chk("t1_sel_after_e2", {5'd0, bus.select}, 8'd1);
        chk("t1_op1_after_e2", bus.AR_Out_Operand1, 8'h08);
        chk("t1_op2_after_e2", bus.AR_Out_Operand2, 8'h04);
        tick();

        // Fill with waiting instructions; the fifth is dropped.
        do_reset();
        drive(8'h01, 8'h02, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("full_tag", {5'd0, bus.ADD_Tag_ip}, 8'd0);
        drive(8'h55, 8'h66, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("full_drop_ars", {7'd0, bus.AR_Status}, 8'd0);
        tick();
        do_reset();

        // Entries 2 and 3 ready while the adder is busy, then released.
        drive(8'h01, 8'h02, 3'd1, 3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(8'h28, 8'h44, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(8'h08, 8'h04, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(8'h01, 8'h02, 3'd1, 3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("busy_hold_ars", {7'd0, bus.AR_Status}, 8'd0);
        drive(8'h01, 8'h02, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("rel_sel2", {5'd0, bus.select}, 8'd2);
        chk("rel_op1_28", bus.AR_Out_Operand1, 8'h28);
        chk("rel_tag_freed", {5'd0, bus.ADD_Tag_ip}, 8'd2);
        tick();
        chk("rel_sel3", {5'd0, bus.select}, 8'd3);
        chk("rel_op2_04", bus.AR_Out_Operand2, 8'h04);
        chk("rel_tag_after_same_edge", {5'd0, bus.ADD_Tag_ip}, 8'd3);
        tick();

        // Reset in the middle of operation discards entries at once.
        do_reset();

`ifdef ADD_RS_CDB_EN
        drive(8'h00, 8'h08, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(8'h00, 8'h00, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0);
        set_cdb(1'b1, 3'd5, 8'h28);
        tick();
        set_cdb(1'b0, 3'd0, 8'h00);
        tick();
        chk("cdb_sel1", {5'd0, bus.select}, 8'd1);
        chk("cdb_op1_28", bus.AR_Out_Operand1, 8'h28);
        do_reset();
`endif

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            drive(8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                  $urandom_range(7, 0) != 0, $urandom_range(7, 0) != 0, $urandom_range(3, 0) == 0);
            set_cdb($urandom_range(1, 0) == 1, 3'($urandom_range(7, 0)), 8'($urandom));
            tick();
            if ($urandom_range(39, 0) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
